// File: rtl/sdram_arbit_pkg.sv
// Shared definitions for the SDRAM command-bus arbiter: command encodings,
// FSM state encoding and default bus widths.
package sdram_arbit_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 13;
  localparam int BANK_W_DEF = 2;

  // Width of the grant-timeout counter; TIMEOUT must fit in it.
  localparam int CNT_W = 10;

  // Commands are {cs_n, ras_n, cas_n, we_n}.
  typedef logic [3:0] cmd_t;
  localparam cmd_t CMD_NOP  = 4'b0111;
  localparam cmd_t CMD_ACT  = 4'b0011;
  localparam cmd_t CMD_RD   = 4'b0101;
  localparam cmd_t CMD_WR   = 4'b0100;
  localparam cmd_t CMD_PRE  = 4'b0010;
  localparam cmd_t CMD_AREF = 4'b0001;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } state_t;

  // True for the states in which one engine owns the bus.
  function automatic logic is_grant(input state_t s);
    return (s == ST_AREF) || (s == ST_WRITE) || (s == ST_READ);
  endfunction

endpackage

// File: rtl/sdram_arbit_if.sv
// Engine-side and pin-side signals of the arbiter. The arbiter uses the
// slave view; the engines/pins (or a bench) use the master view.
interface sdram_arbit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13,
  parameter int BANK_W = 2
) ();
  // init engine
  logic              init_end;
  logic [3:0]        init_cmd;
  logic [BANK_W-1:0] init_bank;
  logic [ADDR_W-1:0] init_addr;
  // auto-refresh engine
  logic              aref_req;
  logic              aref_end;
  logic [3:0]        aref_cmd;
  logic [ADDR_W-1:0] aref_addr;
  logic              aref_en;
  // write engine
  logic              wr_req;
  logic              wr_end;
  logic [3:0]        wr_cmd;
  logic [BANK_W-1:0] wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_sdram_en;
  logic [DATA_W-1:0] wr_sdram_data;
  logic              wr_en;
  // read engine
  logic              rd_req;
  logic              rd_end;
  logic [3:0]        rd_cmd;
  logic [BANK_W-1:0] rd_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  // SDRAM pins and status
  logic              sdram_cke;
  logic              sdram_cs_n;
  logic              sdram_ras_n;
  logic              sdram_cas_n;
  logic              sdram_we_n;
  logic [BANK_W-1:0] sdram_ba;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_dq_out;
  logic              sdram_dq_oe;
  logic              arb_err;

  modport slave (
    input  init_end, init_cmd, init_bank, init_addr,
    input  aref_req, aref_end, aref_cmd, aref_addr,
    input  wr_req, wr_end, wr_cmd, wr_bank, wr_addr, wr_sdram_en, wr_sdram_data,
    input  rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
    output aref_en, wr_en, rd_en,
    output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    output sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe, arb_err
  );

  modport master (
    output init_end, init_cmd, init_bank, init_addr,
    output aref_req, aref_end, aref_cmd, aref_addr,
    output wr_req, wr_end, wr_cmd, wr_bank, wr_addr, wr_sdram_en, wr_sdram_data,
    output rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
    input  aref_en, wr_en, rd_en,
    input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    input  sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe, arb_err
  );
endinterface

// File: rtl/sdram_arbit_mux.sv
// Combinational pin mux: routes the bus owner's command/bank/address and the
// write data onto the SDRAM pins. ARBIT (idle) drives NOP with all-ones
// bank/address so the bus is quiet between grants.
module sdram_arbit_mux
  import sdram_arbit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BANK_W = BANK_W_DEF
) (
  input  state_t            state,
  input  logic [3:0]        init_cmd,
  input  logic [BANK_W-1:0] init_bank,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [3:0]        aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic [3:0]        wr_cmd,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_sdram_data,
  input  logic [3:0]        rd_cmd,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [3:0]        cmd,
  output logic [BANK_W-1:0] ba,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dq_out,
  output logic              dq_oe
);

  // Select command/bank/address from the engine that owns the bus.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a value unassigned and no latch is inferred.
    cmd  = CMD_NOP;
    ba   = '1;
    addr = '1;
    case (state)
      ST_INIT: begin
        cmd  = init_cmd;
        ba   = init_bank;
        addr = init_addr;
      end
      ST_AREF: begin
        cmd  = aref_cmd;
        addr = aref_addr;
      end
      ST_WRITE: begin
        cmd  = wr_cmd;
        ba   = wr_bank;
        addr = wr_addr;
      end
      ST_READ: begin
        cmd  = rd_cmd;
        ba   = rd_bank;
        addr = rd_addr;
      end
      default: ;
    endcase
  end

  // dq is driven only by a granted write engine that asks for it.
  assign dq_oe  = (state == ST_WRITE) && wr_sdram_en;
  assign dq_out = dq_oe ? wr_sdram_data : '0;

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter. Holds the bus for the init engine until
// init_end, then grants it to one engine at a time: refresh first, write and
// read alternating when both wait. A grant held too long without its end
// pulse is revoked and flagged on the sticky arb_err.
module sdram_arbit
  import sdram_arbit_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int BANK_W  = BANK_W_DEF,
  parameter int TIMEOUT = 1023
) (
  input  logic        arb_clk,
  input  logic        arb_rst_n,
  sdram_arbit_if.slave bus
);

  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);

  state_t            state;
  state_t            state_nx;
  logic              last_wr;
  logic [CNT_W-1:0]  tmo_cnt;
  logic              tmo_hit;
  logic              arb_err_q;
  logic              cke_q;
  logic [3:0]        cmd;

  // Next-state decision: arbitration in ARBIT, release on end pulse or timeout.
  always_comb begin
    state_nx = state;
    tmo_hit  = 1'b0;
    case (state)
      ST_INIT:
        if (bus.init_end) state_nx = ST_ARBIT;
      ST_ARBIT: begin
        if (bus.aref_req)                 state_nx = ST_AREF;
        else if (bus.wr_req && bus.rd_req) state_nx = last_wr ? ST_READ : ST_WRITE;
        else if (bus.wr_req)              state_nx = ST_WRITE;
        else if (bus.rd_req)              state_nx = ST_READ;
      end
      ST_AREF:
        if (bus.aref_end) state_nx = ST_ARBIT;
        else if (tmo_cnt == TMO_CNT) begin
          state_nx = ST_ARBIT;
          tmo_hit  = 1'b1;
        end
      ST_WRITE:
        if (bus.wr_end) state_nx = ST_ARBIT;
        else if (tmo_cnt == TMO_CNT) begin
          state_nx = ST_ARBIT;
          tmo_hit  = 1'b1;
        end
      ST_READ:
        if (bus.rd_end) state_nx = ST_ARBIT;
        else if (tmo_cnt == TMO_CNT) begin
          state_nx = ST_ARBIT;
          tmo_hit  = 1'b1;
        end
      default: state_nx = ST_INIT;
    endcase
  end

  // State register.
  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!arb_rst_n) state <= ST_INIT;
    else            state <= state_nx;
  end

  // Remember which of write/read was granted last for alternation.
  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n) begin
      last_wr <= 1'b0;
    end else if (state_nx != state) begin
      if (state_nx == ST_WRITE)     last_wr <= 1'b1;
      else if (state_nx == ST_READ) last_wr <= 1'b0;
    end
  end

  // Grant-age counter: cleared on any state change, counts while granted.
  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n)             tmo_cnt <= '0;
    else if (state_nx != state) tmo_cnt <= '0;
    else if (is_grant(state))   tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n)   arb_err_q <= 1'b0;
    else if (tmo_hit) arb_err_q <= 1'b1;
  end

  // Clock enable rises on the first edge after reset release and stays high.
  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n) cke_q <= 1'b0;
    else            cke_q <= 1'b1;
  end

  sdram_arbit_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BANK_W (BANK_W)
  ) u_mux (
    .state         (state),
    .init_cmd      (bus.init_cmd),
    .init_bank     (bus.init_bank),
    .init_addr     (bus.init_addr),
    .aref_cmd      (bus.aref_cmd),
    .aref_addr     (bus.aref_addr),
    .wr_cmd        (bus.wr_cmd),
    .wr_bank       (bus.wr_bank),
    .wr_addr       (bus.wr_addr),
    .wr_sdram_en   (bus.wr_sdram_en),
    .wr_sdram_data (bus.wr_sdram_data),
    .rd_cmd        (bus.rd_cmd),
    .rd_bank       (bus.rd_bank),
    .rd_addr       (bus.rd_addr),
    .cmd           (cmd),
    .ba            (bus.sdram_ba),
    .addr          (bus.sdram_addr),
    .dq_out        (bus.sdram_dq_out),
    .dq_oe         (bus.sdram_dq_oe)
  );

  // Enables follow the state directly so they drop the cycle after an end.
  assign bus.aref_en     = (state == ST_AREF);
  assign bus.wr_en       = (state == ST_WRITE);
  assign bus.rd_en       = (state == ST_READ);
  assign bus.sdram_cke   = cke_q;
  assign bus.arb_err     = arb_err_q;
  assign bus.sdram_cs_n  = cmd[3];
  assign bus.sdram_ras_n = cmd[2];
  assign bus.sdram_cas_n = cmd[1];
  assign bus.sdram_we_n  = cmd[0];

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit. Stimulus pushes each expected grant (engine and
// cycle) into a queue; a monitor pops and compares on every rising enable.
// Pin, dq, cke and error-flag values are checked directly against constants.
module tb_sdram_arbit;
  import sdram_arbit_pkg::*;

  typedef enum logic [1:0] {G_AREF, G_WR, G_RD} gnt_e;
  typedef struct {
    gnt_e kind;
    int   cyc;
  } exp_t;

  logic arb_clk   = 1'b0;
  logic arb_rst_n = 1'b0;
  always #5 arb_clk = ~arb_clk;

  sdram_arbit_if bus ();

  sdram_arbit dut (
    .arb_clk   (arb_clk),
    .arb_rst_n (arb_rst_n),
    .bus       (bus)
  );

  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errs   = 0;
  exp_t exp_q[$];

  always @(posedge arb_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2:0] gnt_bits(input gnt_e k);
    case (k)
      G_AREF:  return 3'b100;
      G_WR:    return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  function automatic logic [3:0] pins();
    return {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n};
  endfunction

  function automatic logic [2:0] ens();
    return {bus.aref_en, bus.wr_en, bus.rd_en};
  endfunction

  task automatic push(input gnt_e k, input int c);
    exp_t e;
    e.kind = k;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge arb_clk);
    #1;
  endtask

  task automatic at(input int c);
    while (cyc < c) tick();
  endtask

  // Grant monitor: every rising enable must match the next queued expectation.
  logic [2:0] en_prev = 3'b000;
  always @(negedge arb_clk) begin
    logic [2:0] en_now;
    exp_t       e;
    en_now = ens();
    if ((en_now & ~en_prev) != 3'b000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", {29'd0, en_now}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("grant_engine", {29'd0, en_now}, {29'd0, gnt_bits(e.kind)});
        check("grant_cycle", cyc, e.cyc);
      end
    end
    en_prev = en_now;
  end

  // Hard stop if the run ever stalls.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int g;
    int n;
    int bad;

    bus.init_end = 1'b0;   bus.init_cmd = 4'b0010; bus.init_bank = 2'b01; bus.init_addr = 13'h0400;
    bus.aref_req = 1'b0;   bus.aref_end = 1'b0;    bus.aref_cmd  = CMD_AREF; bus.aref_addr = 13'h0ABC;
    bus.wr_req   = 1'b0;   bus.wr_end   = 1'b0;    bus.wr_cmd    = CMD_WR;   bus.wr_bank   = 2'b10;
    bus.wr_addr  = 13'h0123; bus.wr_sdram_en = 1'b0; bus.wr_sdram_data = 16'h0000;
    bus.rd_req   = 1'b0;   bus.rd_end   = 1'b0;    bus.rd_cmd    = CMD_RD;   bus.rd_bank   = 2'b11;
    bus.rd_addr  = 13'h0456;

    // ---- 1: reset, init hold, then idle ARBIT ----
    #2;
    check("rst_cke", {31'd0, bus.sdram_cke}, 32'd0);
    check("rst_enables", {29'd0, ens()}, 32'd0);
    check("rst_pins_init", {28'd0, pins()}, 32'h2);
    check("rst_dq_oe", {31'd0, bus.sdram_dq_oe}, 32'd0);
    check("rst_arb_err", {31'd0, bus.arb_err}, 32'd0);
    tick(); tick();
    arb_rst_n = 1'b1;
    #1;
    check("cke_before_edge", {31'd0, bus.sdram_cke}, 32'd0);
    tick();
    check("cke_after_edge", {31'd0, bus.sdram_cke}, 32'd1);

    bad = 0;
    for (int i = 0; i < 50; i++) begin
      bus.wr_req = (i >= 10 && i < 40);   // request held off during init
      if (pins() !== 4'b0010 || ens() !== 3'b000 || bus.sdram_ba !== 2'b01 ||
          bus.sdram_addr !== 13'h0400 || bus.sdram_cke !== 1'b1) bad++;
      tick();
    end
    check("init_hold_bad_cycles", bad, 32'd0);

    bus.init_end = 1'b1;
    tick();
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (pins() !== CMD_NOP || ens() !== 3'b000 || bus.sdram_ba !== 2'b11 ||
          bus.sdram_addr !== 13'h1FFF) bad++;
      tick();
    end
    check("arbit_idle_bad_cycles", bad, 32'd0);
    check("arbit_pins_nop", {28'd0, pins()}, {28'd0, CMD_NOP});

    // ---- 2: write/read alternation (init_end drop is ignored) ----
    bus.init_end = 1'b0;
    c0 = cyc;
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    push(G_WR, c0 + 1);
    at(c0 + 3);
    check("write_pins_cmd", {28'd0, pins()}, {28'd0, CMD_WR});
    check("write_pins_ba", {30'd0, bus.sdram_ba}, 32'h2);
    check("write_pins_addr", {19'd0, bus.sdram_addr}, 32'h0123);
    at(c0 + 20);
    bus.wr_end = 1'b1;
    push(G_RD, c0 + 22);
    tick();
    bus.wr_end = 1'b0;
    check("wr_en_drops_after_end", {31'd0, bus.wr_en}, 32'd0);
    at(c0 + 25);
    check("read_pins_cmd", {28'd0, pins()}, {28'd0, CMD_RD});
    check("read_pins_addr", {19'd0, bus.sdram_addr}, 32'h0456);
    at(c0 + 40);
    bus.rd_end = 1'b1;
    push(G_WR, c0 + 42);
    tick();
    bus.rd_end = 1'b0;
    bus.rd_req = 1'b0;

    // ---- 4: dq output during the write grant ----
    at(c0 + 45);
    bus.wr_sdram_en   = 1'b1;
    bus.wr_sdram_data = 16'hA5A5;
    #1;
    check("dq_oe_on", {31'd0, bus.sdram_dq_oe}, 32'd1);
    check("dq_out_data", {16'd0, bus.sdram_dq_out}, 32'h0000A5A5);
    bus.wr_sdram_en = 1'b0;
    #1;
    check("dq_oe_off", {31'd0, bus.sdram_dq_oe}, 32'd0);
    check("dq_out_zero", {16'd0, bus.sdram_dq_out}, 32'd0);
    at(c0 + 48);
    bus.wr_end = 1'b1;
    bus.wr_req = 1'b0;
    tick();
    bus.wr_end = 1'b0;
    bus.wr_sdram_en   = 1'b1;
    bus.wr_sdram_data = 16'h5A5A;
    #1;
    check("dq_oe_arbit", {31'd0, bus.sdram_dq_oe}, 32'd0);
    check("dq_out_arbit", {16'd0, bus.sdram_dq_out}, 32'd0);
    bus.wr_sdram_en = 1'b0;
    tick(); tick();

    // ---- 3: refresh waits for read, then beats a pending write ----
    c0 = cyc;
    bus.rd_req = 1'b1;
    push(G_RD, c0 + 1);
    at(c0 + 5);
    bus.aref_req = 1'b1;
    bus.wr_req   = 1'b1;
    at(c0 + 10);
    check("read_not_preempted", {31'd0, bus.rd_en}, 32'd1);
    bus.rd_end = 1'b1;
    bus.rd_req = 1'b0;
    push(G_AREF, c0 + 12);
    tick();
    bus.rd_end = 1'b0;
    at(c0 + 13);
    check("aref_pins_cmd", {28'd0, pins()}, {28'd0, CMD_AREF});
    check("aref_pins_ba", {30'd0, bus.sdram_ba}, 32'h3);
    check("aref_pins_addr", {19'd0, bus.sdram_addr}, 32'h0ABC);
    at(c0 + 15);
    bus.aref_end = 1'b1;
    bus.aref_req = 1'b0;
    push(G_WR, c0 + 17);
    tick();
    bus.aref_end = 1'b0;
    at(c0 + 18);
    bus.wr_end = 1'b1;
    bus.wr_req = 1'b0;
    tick();
    bus.wr_end = 1'b0;
    tick(); tick();

    // ---- end pulse on the last allowed cycle: normal end, no error ----
    c0 = cyc;
    g  = c0 + 1;
    bus.rd_req = 1'b1;
    push(G_RD, g);
    at(g + 1);
    bus.rd_req = 1'b0;
    at(g + 1023);
    check("late_end_still_granted", {31'd0, bus.rd_en}, 32'd1);
    bus.rd_end = 1'b1;
    tick();
    bus.rd_end = 1'b0;
    check("late_end_released", {31'd0, bus.rd_en}, 32'd0);
    check("late_end_no_err", {31'd0, bus.arb_err}, 32'd0);
    tick(); tick();

    // ---- 5: read grant timeout, stray wr_end ignored ----
    c0 = cyc;
    bus.rd_req = 1'b1;
    push(G_RD, c0 + 1);
    at(c0 + 1);
    bus.rd_req = 1'b0;
    n = 0;
    while (bus.rd_en === 1'b1 && n < 1100) begin
      bus.wr_end = (n == 100);
      n++;
      tick();
    end
    bus.wr_end = 1'b0;
    if (!(n >= 1023 && n <= 1024))
      $display("note: read grant lasted %0d cycles", n);
    check("timeout_len_in_range", {31'd0, (n >= 1023 && n <= 1024)}, 32'd1);
    check("timeout_arb_err", {31'd0, bus.arb_err}, 32'd1);
    check("timeout_enables", {29'd0, ens()}, 32'd0);
    check("timeout_pins_nop", {28'd0, pins()}, {28'd0, CMD_NOP});
    c0 = cyc;
    bus.wr_req = 1'b1;
    push(G_WR, c0 + 1);
    at(c0 + 3);
    bus.wr_end = 1'b1;
    bus.wr_req = 1'b0;
    tick();
    bus.wr_end = 1'b0;
    tick();
    check("arb_err_sticky", {31'd0, bus.arb_err}, 32'd1);

    // ---- 6: reset mid-write, then wait for init_end again ----
    c0 = cyc;
    bus.wr_req = 1'b1;
    push(G_WR, c0 + 1);
    at(c0 + 3);
    bus.wr_sdram_en   = 1'b1;
    bus.wr_sdram_data = 16'h1234;
    #1;
    check("pre_reset_oe", {31'd0, bus.sdram_dq_oe}, 32'd1);
    arb_rst_n = 1'b0;
    #1;
    check("async_rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    check("async_rst_oe", {31'd0, bus.sdram_dq_oe}, 32'd0);
    check("async_rst_arb_err", {31'd0, bus.arb_err}, 32'd0);
    check("async_rst_cke", {31'd0, bus.sdram_cke}, 32'd0);
    check("async_rst_pins_init", {28'd0, pins()}, 32'h2);
    bus.wr_sdram_en = 1'b0;
    tick(); tick();
    arb_rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ens() !== 3'b000 || pins() !== 4'b0010) bad++;
    end
    check("reinit_wait_bad_cycles", bad, 32'd0);
    c0 = cyc;
    bus.init_end = 1'b1;
    push(G_WR, c0 + 2);
    at(c0 + 5);
    bus.wr_end = 1'b1;
    bus.wr_req = 1'b0;
    tick();
    bus.wr_end = 1'b0;
    tick(); tick(); tick();

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
